txt_overlay_draw: RTL

//  Reader side of the text-ROM interface. Sits in the VGA draw chain. Per pixel it computes

---
 rtl/txt_overlay_draw_pkg.sv | 30 +++
 rtl/txt_overlay_draw_if.sv | 29 ++
 rtl/txt_overlay_draw_delay.sv | 30 +++
 rtl/txt_overlay_draw.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/txt_overlay_draw_pkg.sv
// Shared constants and types for the text overlay draw stage.
//   CHAR_W / CHAR_H    glyph size in pixels (font byte width, font line count)
//   FONT_ADDR_W        font ROM address width: {char_code, line}
//   CHAR_XY_W          text ROM address width: {row, col}
//   PIPE_LAT           input-to-output latency in clocks
//   timing_t           raster timing plus background colour, carried down the pipe
package txt_overlay_draw_pkg;

   localparam int CHAR_W      = 8;
   localparam int CHAR_H      = 16;
   localparam int CNT_W       = 11;
   localparam int RGB_W       = 12;
   localparam int CODE_W      = 7;
   localparam int LINE_W      = 4;
   localparam int BIT_W       = 3;
   localparam int FONT_ADDR_W = CODE_W + LINE_W;
   localparam int CHAR_XY_W   = 8;
   localparam int PIPE_LAT    = 4;

   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic [CNT_W-1:0] vcount;
      logic             hsync;
      logic             vsync;
      logic             hblnk;
      logic             vblnk;
      logic [RGB_W-1:0] rgb;
   } timing_t;

endpackage

// File: rtl/txt_overlay_draw_if.sv
// Text ROM / font ROM read bus.
//   char_xy     drawer -> text ROM   {row[3:0], col[3:0]}
//   char_code   text ROM -> drawer   valid 1 clk after char_xy
//   font_addr   drawer -> font ROM   {char_code, line[3:0]}
//   font_pixels font ROM -> drawer   valid 1 clk after font_addr, bit7 = leftmost
// master = drawer, slave = ROM side.
interface txt_overlay_draw_if;
   import txt_overlay_draw_pkg::*;

   logic [CHAR_XY_W-1:0]   char_xy;
   logic [CODE_W-1:0]      char_code;
   logic [FONT_ADDR_W-1:0] font_addr;
   logic [CHAR_W-1:0]      font_pixels;

   modport master (
      output char_xy,
      output font_addr,
      input  char_code,
      input  font_pixels
   );

   modport slave (
      input  char_xy,
      input  font_addr,
      output char_code,
      output font_pixels
   );

endinterface

// File: rtl/txt_overlay_draw_delay.sv
// Fixed-length shift register with async active-high reset.
//   clk, rst   clock / async reset (clears every stage)
//   din        WIDTH-bit input
//   dout       din delayed by CLK_DEL clocks (CLK_DEL >= 1)
module txt_overlay_draw_delay #(
   parameter int WIDTH   = 1,
   parameter int CLK_DEL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [CLK_DEL-1:0][WIDTH-1:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < CLK_DEL; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign dout = sr[CLK_DEL-1];

endmodule

// File: rtl/txt_overlay_draw.sv
// Text overlay draw stage in the VGA chain. Looks up the character under each pixel
// in a text ROM, then the glyph line in a font ROM, and paints FG_COLOR on set glyph
// bits inside the text box. Everything is delayed 4 clocks so output stays aligned.
//   clk, rst                         pixel clock, async active-high reset
//   text_en, pos_x, pos_y            overlay enable and box top-left, taken at frame start
//   hcount_in .. vblnk_in, rgb_in    incoming raster timing and background colour
//   rom                              text/font ROM read bus (master side)
//   hcount_out .. vblnk_out, rgb_out timing and colour, 4 clocks later
module txt_overlay_draw
   import txt_overlay_draw_pkg::*;
#(
   parameter int               COLS     = 16,
   parameter int               ROWS     = 1,
   parameter logic [RGB_W-1:0] FG_COLOR = 12'hFFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               text_en,
   input  logic [CNT_W-1:0]   pos_x,
   input  logic [CNT_W-1:0]   pos_y,
   input  logic [CNT_W-1:0]   hcount_in,
   input  logic [CNT_W-1:0]   vcount_in,
   input  logic               hsync_in,
   input  logic               vsync_in,
   input  logic               hblnk_in,
   input  logic               vblnk_in,
   input  logic [RGB_W-1:0]   rgb_in,
   txt_overlay_draw_if.master rom,
   output logic [CNT_W-1:0]   hcount_out,
   output logic [CNT_W-1:0]   vcount_out,
   output logic               hsync_out,
   output logic               vsync_out,
   output logic               hblnk_out,
   output logic               vblnk_out,
   output logic [RGB_W-1:0]   rgb_out
);

   localparam logic [CNT_W-1:0] BOX_W = CNT_W'(COLS * CHAR_W);
   localparam logic [CNT_W-1:0] BOX_H = CNT_W'(ROWS * CHAR_H);

   logic             frame_start;
   logic [CNT_W-1:0] pos_x_q, pos_y_q;
   logic             en_q;
   logic [CNT_W-1:0] pos_x_eff, pos_y_eff;
   logic             en_eff;
   logic [CNT_W-1:0] rel_x, rel_y;
   logic             in_box;

   logic [CHAR_XY_W-1:0] char_xy_q;
   logic [LINE_W-1:0]    line_d1, line_d2;
   logic [BIT_W-1:0]     bit_d1, bit_d3;
   logic                 in_box_d1, in_box_d3;
   logic                 pix;

   timing_t tim_in, tim_d3, tim_out;

   assign frame_start = (vcount_in == '0) && (hcount_in == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_x_q <= '0;
         pos_y_q <= '0;
         en_q    <= 1'b0;
      end else if (frame_start) begin
         pos_x_q <= pos_x;
         pos_y_q <= pos_y;
         en_q    <= text_en;
      end
   end

   // The frame-start pixel itself already belongs to the new frame.
   assign pos_x_eff = frame_start ? pos_x   : pos_x_q;
   assign pos_y_eff = frame_start ? pos_y   : pos_y_q;
   assign en_eff    = frame_start ? text_en : en_q;

   assign rel_x = hcount_in - pos_x_eff;
   assign rel_y = vcount_in - pos_y_eff;

   // The >= checks stop a box near 2047 from wrapping onto the left/top edge.
   assign in_box = en_eff
                   && (hcount_in >= pos_x_eff) && (rel_x < BOX_W)
                   && (vcount_in >= pos_y_eff) && (rel_y < BOX_H)
                   && !hblnk_in && !vblnk_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         char_xy_q <= '0;
         line_d1   <= '0;
         bit_d1    <= '0;
         in_box_d1 <= 1'b0;
      end else begin
         char_xy_q <= in_box ? {rel_y[7:4], rel_x[6:3]} : '0;
         line_d1   <= rel_y[3:0];
         bit_d1    <= rel_x[2:0];
         in_box_d1 <= in_box;
      end
   end

   assign rom.char_xy = char_xy_q;

   // Line must meet char_code (text ROM registers once).
   txt_overlay_draw_delay #(.WIDTH(LINE_W), .CLK_DEL(1)) u_line_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (line_d1),
      .dout (line_d2)
   );

   // Bit select and box flag must meet font_pixels (both ROMs register).
   txt_overlay_draw_delay #(.WIDTH(BIT_W), .CLK_DEL(2)) u_bit_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (bit_d1),
      .dout (bit_d3)
   );

   txt_overlay_draw_delay #(.WIDTH(1), .CLK_DEL(2)) u_inbox_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (in_box_d1),
      .dout (in_box_d3)
   );

   assign rom.font_addr = {rom.char_code, line_d2};

   assign pix = rom.font_pixels[3'd7 - bit_d3] & in_box_d3;

   assign tim_in = '{hcount: hcount_in, vcount: vcount_in,
                     hsync: hsync_in, vsync: vsync_in,
                     hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

   // Timing runs PIPE_LAT-1 in the shifter; the output register supplies the last clock.
   txt_overlay_draw_delay #(.WIDTH($bits(timing_t)), .CLK_DEL(PIPE_LAT - 1)) u_tim_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (tim_in),
      .dout (tim_d3)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tim_out <= '0;
      end else begin
         tim_out <= tim_d3;
         if (pix) begin
            tim_out.rgb <= FG_COLOR;
         end
      end
   end

   assign hcount_out = tim_out.hcount;
   assign vcount_out = tim_out.vcount;
   assign hsync_out  = tim_out.hsync;
   assign vsync_out  = tim_out.vsync;
   assign hblnk_out  = tim_out.hblnk;
   assign vblnk_out  = tim_out.vblnk;
   assign rgb_out    = tim_out.rgb;

endmodule
